// File: rtl/spike_matrix_pkg.sv
// Shared types and defaults for the spike accumulation scheduler.
package spike_matrix_pkg;

  localparam int unsigned SPK_N      = 4;
  localparam int unsigned SPK_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_e;

  // Returns {sat, sum}; sum clamps to all-ones when the carry is set.
  function automatic logic [SPK_DATA_W:0] sat_add(input logic [SPK_DATA_W-1:0] a,
                                                  input logic [SPK_DATA_W-1:0] b);
    logic [SPK_DATA_W:0] raw;
    raw = {1'b0, a} + {1'b0, b};
    if (raw[SPK_DATA_W]) sat_add = {1'b1, {SPK_DATA_W{1'b1}}};
    else                 sat_add = raw;
  endfunction

endpackage

// File: rtl/spike_accum_scheduler_sat_adder.sv
// Combinational unsigned saturating adder; the single shared datapath of the scheduler.
module spike_sat_adder
  import spike_matrix_pkg::*;
#(
  parameter int unsigned DATA_W = SPK_DATA_W
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              sat_o
);

  logic [DATA_W:0] raw;

  assign raw   = {1'b0, a_i} + {1'b0, b_i};
  assign sat_o = raw[DATA_W];
  assign sum_o = raw[DATA_W] ? '1 : raw[DATA_W-1:0];

endmodule

// File: rtl/spike_accum_scheduler.sv
// Scans every (dst, src) pair once per accepted spike epoch, accumulating snapshotted
// source data into destination accumulators through one shared saturating adder.
module spike_accum_scheduler
  import spike_matrix_pkg::*;
#(
  parameter int unsigned N      = SPK_N,
  parameter int unsigned DATA_W = SPK_DATA_W,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_src,
  input  logic [IDX_W-1:0]    cfg_dst,
  input  logic                cfg_conn,
  output logic                cfg_ready,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        in_spikes,
  input  logic [N*DATA_W-1:0] in_data,
  output logic                busy,
  output logic                done,
  output logic [N*DATA_W-1:0] acc_out,
  output logic [N-1:0]        sat_flag
);

  localparam int unsigned CNT_W = 2 * IDX_W;
  localparam int unsigned LAST  = N * N - 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       adj_q  [N];
  logic [N-1:0]       adj_d  [N];
  logic [N-1:0]       spk_q, spk_d;
  logic [DATA_W-1:0]  data_q [N];
  logic [DATA_W-1:0]  data_d [N];
  logic [DATA_W-1:0]  acc_q  [N];
  logic [DATA_W-1:0]  acc_d  [N];
  logic [N-1:0]       sat_q, sat_d;

  logic [IDX_W-1:0]   dst, src;
  logic               hit;
  logic [DATA_W-1:0]  add_sum;
  logic               add_sat;

  // Row-major by destination: upper counter bits pick dst, lower bits pick src.
  assign dst = cnt_q[CNT_W-1:IDX_W];
  assign src = cnt_q[IDX_W-1:0];
  assign hit = (state_q == SCAN) && adj_q[src][dst] && spk_q[src] && (src != dst);

  spike_sat_adder #(.DATA_W(DATA_W)) u_adder (
    .a_i   (acc_q[dst]),
    .b_i   (data_q[src]),
    .sum_o (add_sum),
    .sat_o (add_sat)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adj_d   = adj_q;
    spk_d   = spk_q;
    data_d  = data_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: begin
        if (cfg_we) adj_d[cfg_src][cfg_dst] = cfg_conn;
        if (in_valid) begin
          spk_d = in_spikes;
          for (int unsigned i = 0; i < N; i++) begin
            data_d[i] = in_data[i*DATA_W +: DATA_W];
            acc_d[i]  = '0;
          end
          sat_d   = '0;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          acc_d[dst] = add_sum;
          if (add_sat) sat_d[dst] = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LAST)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adj_q   <= '{default: '0};
      spk_q   <= '0;
      data_q  <= '{default: '0};
      acc_q   <= '{default: '0};
      sat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adj_q   <= adj_d;
      spk_q   <= spk_d;
      data_q  <= data_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign sat_flag  = sat_q;

  for (genvar g = 0; g < N; g++) begin : g_acc_out
    assign acc_out[g*DATA_W +: DATA_W] = acc_q[g];
  end

endmodule

// File: tb/tb_spike_accum_scheduler.sv
// Scoreboard bench: epochs push expected sums computed from the adjacency model; a monitor checks on done.
module tb_spike_accum_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_we;
  logic [1:0]     cfg_src, cfg_dst;
  logic           cfg_conn;
  logic           cfg_ready;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_spikes;
  logic [N*W-1:0] in_data;
  logic           busy, done;
  logic [N*W-1:0] acc_out;
  logic [N-1:0]   sat_flag;

  typedef struct {
    logic [N*W-1:0] acc;
    logic [N-1:0]   sat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   adj_m [N][N];

  spike_accum_scheduler #(.N(N), .DATA_W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_we    (cfg_we),
    .cfg_src   (cfg_src),
    .cfg_dst   (cfg_dst),
    .cfg_conn  (cfg_conn),
    .cfg_ready (cfg_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_spikes (in_spikes),
    .in_data   (in_data),
    .busy      (busy),
    .done      (done),
    .acc_out   (acc_out),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Sum of connected, spiking, non-self sources per destination, clamped to 8 bits.
  function automatic exp_t model(logic [N-1:0] sp, logic [N*W-1:0] dt);
    exp_t e;
    int   total;
    logic [W-1:0] dv;
    e.acc = '0;
    e.sat = '0;
    for (int d = 0; d < N; d++) begin
      total = 0;
      for (int s = 0; s < N; s++)
        if (s != d && adj_m[s][d] && sp[s]) begin
          dv = dt[s*W +: W];
          total += int'(dv);
        end
      if (total > 255) begin
        e.acc[d*W +: W] = 8'hFF;
        e.sat[d] = 1'b1;
      end else begin
        e.acc[d*W +: W] = total[W-1:0];
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_unexpected: got done=1 expected no pending epoch");
      end else begin
        e = sb.pop_front();
        check("acc_out", 64'(acc_out), 64'(e.acc));
        check("sat_flag", 64'(sat_flag), 64'(e.sat));
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic cfg(input int s, input int d, input bit c);
    @(negedge clk);
    wait_ready();
    check("cfg_ready", 64'(cfg_ready), 64'd1);
    cfg_we   = 1'b1;
    cfg_src  = 2'(s);
    cfg_dst  = 2'(d);
    cfg_conn = c;
    adj_m[s][d] = c;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic epoch(input logic [N-1:0] sp, input logic [N*W-1:0] dt,
                       input bit wr, input int cs, input int cd, input bit cc);
    int lat;
    @(negedge clk);
    wait_ready();
    in_valid  = 1'b1;
    in_spikes = sp;
    in_data   = dt;
    if (wr) begin
      cfg_we   = 1'b1;
      cfg_src  = 2'(cs);
      cfg_dst  = 2'(cd);
      cfg_conn = cc;
      adj_m[cs][cd] = cc;
    end
    sb.push_back(model(sp, dt));
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    in_spikes = 4'($urandom);
    in_data   = $urandom;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 3) begin
        check("busy_scan", 64'(busy), 64'd1);
        check("in_ready_scan", 64'(in_ready), 64'd0);
      end
      if (done) break;
    end
    check("done_latency", 64'(lat), 64'd16);
    @(posedge clk);
    #1;
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("busy_after", 64'(busy), 64'd0);
    check("done_pulse", 64'(done), 64'd0);
  endtask

  task automatic scan_interference();
    int n;
    bit r;
    logic [N*W-1:0] db;
    logic [N-1:0]   spb;
    @(negedge clk);
    wait_ready();
    in_valid  = 1'b1;
    in_spikes = 4'b1111;
    in_data   = $urandom;
    sb.push_back(model(4'b1111, in_data));
    @(posedge clk);
    #1;
    db = $urandom;
    db[0] = 1'b1;
    spb = 4'($urandom) | 4'b0001;
    in_spikes = spb;
    in_data   = db;
    cfg_we    = 1'b1;
    cfg_src   = 2'd0;
    cfg_dst   = 2'd1;
    cfg_conn  = 1'b0;
    n = 0;
    r = 1'b0;
    while (!r && n < 40) begin
      if (n == 5) cfg_we = 1'b0;
      r = in_ready;
      @(posedge clk);
      n++;
      #1;
    end
    sb.push_back(model(spb, db));
    in_valid = 1'b0;
    check("b2b_period", 64'(n), 64'd18);
    @(negedge clk);
    wait_ready();
  endtask

  initial begin
    reset = 1'b1;
    cfg_we = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_conn = 1'b0;
    in_valid = 1'b0; in_spikes = '0; in_data = '0;
    for (int s = 0; s < N; s++)
      for (int d = 0; d < N; d++) adj_m[s][d] = 1'b0;
    #22;
    check("rst_acc", 64'(acc_out), 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;

    epoch(4'b1111, 32'h10101010, 1'b0, 0, 0, 1'b0);

    cfg(0, 1, 1'b1); cfg(2, 1, 1'b1); cfg(3, 1, 1'b1);
    epoch(4'b1101, {8'd9, 8'd7, 8'd0, 8'd5}, 1'b0, 0, 0, 1'b0);
    epoch(4'b0101, {8'd9, 8'd7, 8'd0, 8'd5}, 1'b0, 0, 0, 1'b0);

    cfg(0, 3, 1'b1); cfg(1, 3, 1'b1); cfg(2, 3, 1'b1);
    epoch(4'b0111, {8'd100, 8'd100, 8'd100, 8'd100}, 1'b0, 0, 0, 1'b0);

    cfg(2, 2, 1'b1); cfg(1, 2, 1'b1);
    epoch(4'b0110, {8'd0, 8'd50, 8'd3, 8'd0}, 1'b0, 0, 0, 1'b0);

    cfg(0, 1, 1'b1);
    scan_interference();
    epoch(4'b0001, {8'd0, 8'd0, 8'd0, 8'd1}, 1'b0, 0, 0, 1'b0);

    // Concurrent write and accept: the new connection must count in that epoch.
    epoch(4'b0100, {8'd0, 8'd33, 8'd0, 8'd0}, 1'b1, 2, 0, 1'b1);

    repeat (20) begin
      repeat ($urandom_range(0, 2))
        cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
      epoch(4'($urandom), $urandom, ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom));
    end

    cfg(0, 2, 1'b1); cfg(3, 0, 1'b1);
    @(negedge clk);
    wait_ready();
    in_valid  = 1'b1;
    in_spikes = 4'b1111;
    in_data   = $urandom;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_acc", 64'(acc_out), 64'd0);
    check("mid_rst_sat", 64'(sat_flag), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    for (int s = 0; s < N; s++)
      for (int d = 0; d < N; d++) adj_m[s][d] = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    epoch(4'b1111, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
